core_mem_arb: RTL and testbench
===============================

# core_mem_arb

Memory port arbiter and sequencer for the multi-cycle RV32I core. It shares the single memory port (MEM_ADDR/MEM_IN/MEM_OUT/MEM_WE) between the instruction-fetch requester and the load/store requester. It sequences each access over a configurable read latency, generates byte strobes and store-lane replication, and sign/zero-extends load data. It sits between the core's fetch/memory stages and the external memory.

## Interface
- MEM_LAT, default 1: cycles from the first BUSY cycle (address presented) to the MEM_OUT sampling edge; legal values 1..15.

- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- I_REQ  in  1  fetch request; held with I_ADDR stable until I_GNT.
- I_ADDR  in  32  fetch byte address; bits [1:0] ignored.
- I_GNT  out  1  one-cycle grant pulse to the fetch requester.
- I_RVALID  out  1  one-cycle pulse: I_RDATA valid.
- I_RDATA  out  32  raw MEM_OUT word.
- D_REQ  in  1  data request; held with D_* stable until D_GNT.
- D_WE  in  1  1 = store, 0 = load.
- D_SIZE  in  2  00 byte, 01 half, 10/11 word.
- D_UNSIGNED  in  1  load zero-extend (lbu/lhu).
- D_ADDR  in  32  data byte address.
- D_WDATA  in  32  store data, right-aligned.
- D_GNT  out  1  one-cycle grant pulse to the data requester.
- D_RVALID  out  1  one-cycle completion pulse (loads, stores and misaligned accesses).
- D_RDATA  out  32  extended load data; 0 for stores and misaligned accesses.
- D_MISALIGN  out  1  asserted with D_RVALID when the access was misaligned.
- MEM_ADDR  out  32  word-aligned byte address ({addr[31:2],2'b00}).
- MEM_IN  out  32  write data to memory.
- MEM_WE  out  1  write enable.
- MEM_BE  out  4  byte strobes; bit n = byte lane n.
- MEM_OUT  in  32  read data from memory.

## Operation
- States: IDLE, BUSY.
- IDLE: if any request is pending and RST=0, grant one requester combinationally in that cycle. GNT = REQ & selected & (state==IDLE) & !RST. On the same edge, latch the request fields and go to BUSY.
- Arbitration without the macro: fixed priority, data over fetch.
- Misaligned data request (half with addr[0]=1, word with addr[1:0]!=0): the request is granted, but no memory access is made and the state stays IDLE. D_RVALID=1, D_MISALIGN=1 and D_RDATA=0 in the next cycle.
- BUSY, store: one cycle. MEM_WE=1 and MEM_BE/MEM_IN are driven in that cycle. Return to IDLE; D_RVALID pulses in the following cycle.
- BUSY, read: a counter runs 1..MEM_LAT. MEM_OUT is sampled at the edge ending count MEM_LAT, the RVALID/RDATA registers are loaded, and the state returns to IDLE.
- Store lanes:
  - byte: MEM_IN = {4{wdata[7:0]}}, MEM_BE = 1<<addr[1:0].
  - half: MEM_IN = {2{wdata[15:0]}}, MEM_BE = addr[1] ? 1100 : 0011.
  - word: MEM_IN = wdata, MEM_BE = 1111.
- Load extraction: the byte lane is selected by addr[1:0] and the half lane by addr[1]. The result is sign-extended unless D_UNSIGNED=1. Words pass through.
- Fetches never write. I_RDATA = MEM_OUT sampled word.
- MEM_ADDR holds its last value in IDLE. MEM_WE and MEM_BE are 0 outside the store BUSY cycle.
- A request dropped before its grant is ignored, with no side effects.

## Timing
- Reset values: state IDLE, all outputs 0 (MEM_ADDR, MEM_IN, MEM_BE, MEM_WE, both RVALID, RDATA, D_MISALIGN, GNT).
- Read, request in cycle 0 in IDLE:
  - GNT in cycle 0.
  - MEM_ADDR valid in cycles 1..MEM_LAT.
  - RVALID in cycle MEM_LAT+1.
  - Next grant possible in cycle MEM_LAT+1.
- Store: GNT in cycle 0, MEM_WE in cycle 1, D_RVALID in cycle 2, next grant possible in cycle 2.
- Misaligned access: GNT in cycle 0, D_RVALID/D_MISALIGN in cycle 1, next grant possible in cycle 1.
- At most one grant per cycle. No grant while BUSY.
- RST high mid-access: the access is aborted and the state goes to IDLE on that edge. No RVALID is issued for the aborted access, and GNT is 0 while RST=1.

## Configuration
- CORE_MEM_ARB_RR_EN defined: round-robin arbitration. A 1-bit pointer marks the last-granted requester, and on a tie the other requester wins. The pointer resets to "fetch last", so data wins the first tie. The pointer updates only on a grant; misaligned grants count.
- Not defined: fixed priority (data > fetch) and no pointer register.

## Test plan
- MEM_LAT=1, I_REQ with I_ADDR=0x00000102, MEM_OUT=0x00000013 -> I_GNT in cycle 0, MEM_ADDR=0x00000100 in cycle 1, I_RVALID=1 with I_RDATA=0x00000013 in cycle 2.
- Store byte, D_ADDR=0x00000203, D_WDATA=0x000000A5 -> MEM_ADDR=0x00000200, MEM_BE=1000, MEM_IN=0xA5A5A5A5, MEM_WE=1 in cycle 1 only; D_RVALID in cycle 2 with D_RDATA=0.
- MEM_LAT=3, load byte from 0x00000201 with MEM_OUT=0x00008000:
  - signed -> D_RVALID in cycle 4 with D_RDATA=0xFFFFFF80.
  - D_UNSIGNED=1 -> D_RDATA=0x00000080.
- I_REQ and D_REQ held continuously, every data access a load (MEM_LAT=1):
  - without the macro -> every grant goes to data.
  - with CORE_MEM_ARB_RR_EN -> grant order is D, I, D, I at cycles 0, 2, 4, 6.
- Load word at 0x00000102 -> D_GNT in cycle 0, MEM_WE=0 and MEM_ADDR unchanged, D_RVALID=D_MISALIGN=1 with D_RDATA=0 in cycle 1.
- MEM_LAT=3, RST pulsed in cycle 2 of a fetch -> no I_RVALID, all outputs 0 after that edge; an I_REQ in the cycle after RST falls is granted immediately.

Source files
------------

// File: rtl/core_mem_arb_if.sv
// -----------------------------------------------------------------------------
// core_mem_arb_if
// Bundle of the fetch requester, data requester and external memory signals
// that meet at the core_mem_arb memory-port arbiter.
//
// Modports:
//   slave  - the arbiter: takes requests and MEM_OUT, drives grants, responses
//            and the memory address/data/strobe lines.
//   master - the environment (core stages + memory): the mirror of slave.
//
// Signals:
//   I_REQ, I_ADDR[31:0]                 fetch request
//   I_GNT, I_RVALID, I_RDATA[31:0]      fetch grant / response
//   D_REQ, D_WE, D_SIZE[1:0], D_UNSIGNED, D_ADDR[31:0], D_WDATA[31:0]
//                                       data request
//   D_GNT, D_RVALID, D_RDATA[31:0], D_MISALIGN
//                                       data grant / response
//   MEM_ADDR[31:0], MEM_IN[31:0], MEM_WE, MEM_BE[3:0], MEM_OUT[31:0]
//                                       shared memory port
// -----------------------------------------------------------------------------
interface core_mem_arb_if;
  logic        I_REQ;
  logic [31:0] I_ADDR;
  logic        I_GNT;
  logic        I_RVALID;
  logic [31:0] I_RDATA;

  logic        D_REQ;
  logic        D_WE;
  logic [1:0]  D_SIZE;
  logic        D_UNSIGNED;
  logic [31:0] D_ADDR;
  logic [31:0] D_WDATA;
  logic        D_GNT;
  logic        D_RVALID;
  logic [31:0] D_RDATA;
  logic        D_MISALIGN;

  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_IN;
  logic        MEM_WE;
  logic [3:0]  MEM_BE;
  logic [31:0] MEM_OUT;

  modport slave (
    input  I_REQ, I_ADDR,
    input  D_REQ, D_WE, D_SIZE, D_UNSIGNED, D_ADDR, D_WDATA,
    input  MEM_OUT,
    output I_GNT, I_RVALID, I_RDATA,
    output D_GNT, D_RVALID, D_RDATA, D_MISALIGN,
    output MEM_ADDR, MEM_IN, MEM_WE, MEM_BE
  );

  modport master (
    output I_REQ, I_ADDR,
    output D_REQ, D_WE, D_SIZE, D_UNSIGNED, D_ADDR, D_WDATA,
    output MEM_OUT,
    input  I_GNT, I_RVALID, I_RDATA,
    input  D_GNT, D_RVALID, D_RDATA, D_MISALIGN,
    input  MEM_ADDR, MEM_IN, MEM_WE, MEM_BE
  );
endinterface

// File: rtl/core_mem_arb.sv
// -----------------------------------------------------------------------------
// core_mem_arb
// Shares the single memory port between the instruction-fetch requester and
// the load/store requester of the multi-cycle RV32I core. Each access is
// sequenced over MEM_LAT read cycles (stores take one cycle), store data is
// replicated across lanes with matching byte strobes, and load data is
// extracted from its lane and sign/zero-extended.
//
// Parameters:
//   MEM_LAT  cycles from the first BUSY cycle to the MEM_OUT sampling edge
//            (1..15).
//
// Ports:
//   CLK      clock, rising edge
//   RST      synchronous active-high reset
//   bus      core_mem_arb_if.slave (requests, grants, responses, memory port)
//
// Build option:
//   CORE_MEM_ARB_RR_EN  when defined, round-robin arbitration between the two
//                       requesters; otherwise data always beats fetch.
// -----------------------------------------------------------------------------
module core_mem_arb #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          CLK,
  input  logic          RST,
  core_mem_arb_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic        sel_d_reg;     // access in flight belongs to the data requester
  logic        we_reg;        // access in flight is a store
  logic [1:0]  size_reg;
  logic        uns_reg;
  logic [1:0]  lane_reg;      // byte offset of the data access

  logic [31:0] mem_addr_reg;
  logic [31:0] mem_in_reg;
  logic        mem_we_reg;
  logic [3:0]  mem_be_reg;

  logic        i_rvalid_reg;
  logic [31:0] i_rdata_reg;
  logic        d_rvalid_reg;
  logic [31:0] d_rdata_reg;
  logic        d_misalign_reg;

  // ---------------------------------------------------------------------------
  // Arbitration: grants are combinational and only ever issued in IDLE.
  // ---------------------------------------------------------------------------
  logic can_grant;
  logic prio_d;
  logic gnt_d;
  logic gnt_i;

`ifdef CORE_MEM_ARB_RR_EN
  logic last_i_reg;           // 1 = fetch received the most recent grant
  assign prio_d = last_i_reg; // on a tie, whoever did not win last time wins
`else
  assign prio_d = 1'b1;
`endif

  assign can_grant = (state_reg == IDLE) && !RST;
  assign gnt_d     = can_grant && bus.D_REQ && (prio_d || !bus.I_REQ);
  assign gnt_i     = can_grant && bus.I_REQ && !gnt_d;

  logic [31:0] addr_sel;
  assign addr_sel = gnt_d ? bus.D_ADDR : bus.I_ADDR;

  // Misaligned data accesses complete immediately without touching memory.
  logic d_misalign;
  always_comb begin
    d_misalign = 1'b0;
    if (bus.D_SIZE[1]) begin
      d_misalign = |bus.D_ADDR[1:0];
    end else if (bus.D_SIZE[0]) begin
      d_misalign = bus.D_ADDR[0];
    end
  end

  // Store lane replication and strobes, computed from the live request and
  // captured on the grant edge.
  logic [31:0] st_data;
  logic [3:0]  st_be;
  always_comb begin
    st_data = bus.D_WDATA;
    st_be   = 4'b1111;
    if (!bus.D_SIZE[1]) begin
      if (bus.D_SIZE[0]) begin
        st_data = {2{bus.D_WDATA[15:0]}};
        st_be   = bus.D_ADDR[1] ? 4'b1100 : 4'b0011;
      end else begin
        st_data = {4{bus.D_WDATA[7:0]}};
        st_be   = 4'b0001 << bus.D_ADDR[1:0];
      end
    end
  end

  // Load extraction from the returned word.
  logic [7:0] lane_byte [4];
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_byte[gi] = bus.MEM_OUT[8*gi +: 8];
    end
  endgenerate

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  always_comb begin
    ld_byte = lane_byte[lane_reg];
    ld_half = lane_reg[1] ? bus.MEM_OUT[31:16] : bus.MEM_OUT[15:0];
    ld_data = bus.MEM_OUT;
    if (size_reg == 2'b00) begin
      ld_data = {{24{!uns_reg && ld_byte[7]}}, ld_byte};
    end else if (size_reg == 2'b01) begin
      ld_data = {{16{!uns_reg && ld_half[15]}}, ld_half};
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      sel_d_reg      <= 1'b0;
      we_reg         <= 1'b0;
      size_reg       <= 2'b00;
      uns_reg        <= 1'b0;
      lane_reg       <= 2'b00;
      mem_addr_reg   <= 32'd0;
      mem_in_reg     <= 32'd0;
      mem_we_reg     <= 1'b0;
      mem_be_reg     <= 4'd0;
      i_rvalid_reg   <= 1'b0;
      i_rdata_reg    <= 32'd0;
      d_rvalid_reg   <= 1'b0;
      d_rdata_reg    <= 32'd0;
      d_misalign_reg <= 1'b0;
`ifdef CORE_MEM_ARB_RR_EN
      last_i_reg     <= 1'b1;
`endif
    end else begin
      // Response and strobe outputs are single-cycle pulses.
      i_rvalid_reg   <= 1'b0;
      d_rvalid_reg   <= 1'b0;
      d_misalign_reg <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_be_reg     <= 4'd0;

      case (state_reg)
        IDLE: begin
          if (gnt_d && d_misalign) begin
            d_rvalid_reg   <= 1'b1;
            d_misalign_reg <= 1'b1;
            d_rdata_reg    <= 32'd0;
          end else if (gnt_d || gnt_i) begin
            state_reg    <= BUSY;
            cnt_reg      <= 4'd1;
            sel_d_reg    <= gnt_d;
            we_reg       <= gnt_d && bus.D_WE;
            size_reg     <= bus.D_SIZE;
            uns_reg      <= bus.D_UNSIGNED;
            lane_reg     <= addr_sel[1:0];
            mem_addr_reg <= {addr_sel[31:2], 2'b00};
            if (gnt_d && bus.D_WE) begin
              mem_we_reg <= 1'b1;
              mem_be_reg <= st_be;
              mem_in_reg <= st_data;
            end
          end
        end

        BUSY: begin
          if (we_reg) begin
            state_reg    <= IDLE;
            d_rvalid_reg <= 1'b1;
            d_rdata_reg  <= 32'd0;
          end else if (cnt_reg == LAT) begin
            state_reg <= IDLE;
            if (sel_d_reg) begin
              d_rvalid_reg <= 1'b1;
              d_rdata_reg  <= ld_data;
            end else begin
              i_rvalid_reg <= 1'b1;
              i_rdata_reg  <= bus.MEM_OUT;
            end
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end

        default: state_reg <= IDLE;
      endcase

`ifdef CORE_MEM_ARB_RR_EN
      if (gnt_d) begin
        last_i_reg <= 1'b0;
      end else if (gnt_i) begin
        last_i_reg <= 1'b1;
      end
`endif
    end
  end

  assign bus.I_GNT      = gnt_i;
  assign bus.D_GNT      = gnt_d;
  assign bus.I_RVALID   = i_rvalid_reg;
  assign bus.I_RDATA    = i_rdata_reg;
  assign bus.D_RVALID   = d_rvalid_reg;
  assign bus.D_RDATA    = d_rdata_reg;
  assign bus.D_MISALIGN = d_misalign_reg;
  assign bus.MEM_ADDR   = mem_addr_reg;
  assign bus.MEM_IN     = mem_in_reg;
  assign bus.MEM_WE     = mem_we_reg;
  assign bus.MEM_BE     = mem_be_reg;

endmodule

// File: tb/tb_core_mem_arb.sv
// -----------------------------------------------------------------------------
// tb_core_mem_arb
// Self-checking bench for core_mem_arb. Two instances are exercised: one with
// MEM_LAT=1 (bus1) and one with MEM_LAT=3 (bus3). Expected responses are
// pushed to a per-instance queue when a grant is observed and popped when the
// matching RVALID pulse appears. Inputs change on the falling edge and
// outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_core_mem_arb;

  logic CLK = 1'b0;
  logic rst1;
  logic rst3;
  int   total = 0;
  int   bad   = 0;

  always #5 CLK = ~CLK;

  core_mem_arb_if bus1();
  core_mem_arb_if bus3();

  core_mem_arb #(.MEM_LAT(1)) dut1 (.CLK(CLK), .RST(rst1), .bus(bus1.slave));
  core_mem_arb #(.MEM_LAT(3)) dut3 (.CLK(CLK), .RST(rst3), .bus(bus3.slave));

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    bit          mis;
  } exp_t;

  exp_t sb1[$];
  exp_t sb3[$];

  task automatic clear_inputs();
    bus1.I_REQ = 1'b0; bus1.I_ADDR = '0; bus1.D_REQ = 1'b0; bus1.D_WE = 1'b0;
    bus1.D_SIZE = 2'b00; bus1.D_UNSIGNED = 1'b0; bus1.D_ADDR = '0;
    bus1.D_WDATA = '0; bus1.MEM_OUT = '0;
    bus3.I_REQ = 1'b0; bus3.I_ADDR = '0; bus3.D_REQ = 1'b0; bus3.D_WE = 1'b0;
    bus3.D_SIZE = 2'b00; bus3.D_UNSIGNED = 1'b0; bus3.D_ADDR = '0;
    bus3.D_WDATA = '0; bus3.MEM_OUT = '0;
  endtask

  // Advances cycle by cycle until an RVALID pulse is seen on the selected
  // instance; n = cycles advanced, or -1 when the bound expires.
  task automatic wait_rv(input bit which, output int n, output bit is_d,
                         output logic [31:0] data, output bit mis);
    n = -1; is_d = 1'b0; data = '0; mis = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK); #1;
      if (!which) begin
        if (bus1.I_RVALID) begin
          is_d = 1'b0; data = bus1.I_RDATA; mis = 1'b0; n = k;
        end else if (bus1.D_RVALID) begin
          is_d = 1'b1; data = bus1.D_RDATA; mis = bus1.D_MISALIGN; n = k;
        end
      end else begin
        if (bus3.I_RVALID) begin
          is_d = 1'b0; data = bus3.I_RDATA; mis = 1'b0; n = k;
        end else if (bus3.D_RVALID) begin
          is_d = 1'b1; data = bus3.D_RDATA; mis = bus3.D_MISALIGN; n = k;
        end
      end
      if (n >= 0) break;
    end
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst3 = 1'b1;
    repeat (2) @(negedge CLK);
    bus1.I_REQ = 1'b1; bus1.D_REQ = 1'b1; bus3.I_REQ = 1'b1; bus3.D_REQ = 1'b1;
    #1;
    total++;
    if ({bus1.I_GNT, bus1.D_GNT, bus3.I_GNT, bus3.D_GNT} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_gnt: gnt=%b required 0000",
               {bus1.I_GNT, bus1.D_GNT, bus3.I_GNT, bus3.D_GNT});
    end
    total++;
    if ({bus1.MEM_ADDR, bus1.MEM_IN, bus1.MEM_BE, bus1.MEM_WE, bus1.I_RVALID,
         bus1.I_RDATA, bus1.D_RVALID, bus1.D_RDATA, bus1.D_MISALIGN} !== '0) begin
      bad++;
      $display("FAIL reset_out1: addr=%h in=%h be=%b we=%b ivld=%b dvld=%b required all 0",
               bus1.MEM_ADDR, bus1.MEM_IN, bus1.MEM_BE, bus1.MEM_WE,
               bus1.I_RVALID, bus1.D_RVALID);
    end
    total++;
    if ({bus3.MEM_ADDR, bus3.MEM_IN, bus3.MEM_BE, bus3.MEM_WE, bus3.I_RVALID,
         bus3.I_RDATA, bus3.D_RVALID, bus3.D_RDATA, bus3.D_MISALIGN} !== '0) begin
      bad++;
      $display("FAIL reset_out3: addr=%h in=%h be=%b we=%b ivld=%b dvld=%b required all 0",
               bus3.MEM_ADDR, bus3.MEM_IN, bus3.MEM_BE, bus3.MEM_WE,
               bus3.I_RVALID, bus3.D_RVALID);
    end
    @(negedge CLK);
    clear_inputs();
    rst1 = 1'b0; rst3 = 1'b0;
    $display("reset: both instances idle");
  endtask

  task automatic test_fetch();
    int n; bit is_d; logic [31:0] data; bit mis; exp_t e;
    @(negedge CLK);
    bus1.I_REQ = 1'b1; bus1.I_ADDR = 32'h0000_0102; bus1.MEM_OUT = 32'h0000_0013;
    #1;
    total++;
    if ({bus1.I_GNT, bus1.D_GNT} !== 2'b10) begin
      bad++; $display("FAIL fetch_gnt: i/d gnt=%b required 10", {bus1.I_GNT, bus1.D_GNT});
    end
    sb1.push_back('{1'b0, 32'h0000_0013, 1'b0});
    @(negedge CLK);
    bus1.I_REQ = 1'b0;
    #1;
    total++;
    if (bus1.MEM_ADDR !== 32'h0000_0100) begin
      bad++; $display("FAIL fetch_addr: MEM_ADDR=%h required 00000100", bus1.MEM_ADDR);
    end
    total++;
    if ({bus1.I_RVALID, bus1.MEM_WE} !== 2'b00) begin
      bad++; $display("FAIL fetch_busy: rvalid/we=%b required 00", {bus1.I_RVALID, bus1.MEM_WE});
    end
    wait_rv(1'b0, n, is_d, data, mis);
    total++;
    if (n != 1) begin
      bad++; $display("FAIL fetch_lat: rvalid cycle=%0d required 2", n + 1);
    end
    if (n >= 0) begin
      total++;
      if (sb1.size() == 0) begin
        bad++; $display("FAIL fetch_unexpected: response with empty scoreboard");
      end else begin
        e = sb1.pop_front();
        if (is_d !== e.is_d || data !== e.data || mis !== e.mis) begin
          bad++; $display("FAIL fetch_data: d=%b data=%h mis=%b required d=%b data=%h mis=%b",
                          is_d, data, mis, e.is_d, e.data, e.mis);
        end
      end
    end
    $display("fetch addr=00000102 rdata=%h cycle=%0d", data, n + 1);
  endtask

  task automatic test_store();
    logic [31:0] a_t [3] = '{32'h0000_0203, 32'h0000_0012, 32'h0000_0040};
    logic [1:0]  s_t [3] = '{2'b00, 2'b01, 2'b10};
    logic [31:0] w_t [3] = '{32'h0000_00A5, 32'h1234_BEEF, 32'hCAFE_F00D};
    logic [31:0] i_t [3] = '{32'hA5A5_A5A5, 32'hBEEF_BEEF, 32'hCAFE_F00D};
    logic [3:0]  b_t [3] = '{4'b1000, 4'b1100, 4'b1111};
    int n; bit is_d; logic [31:0] data; bit mis; exp_t e;
    logic [31:0] aw;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      bus1.D_REQ = 1'b1; bus1.D_WE = 1'b1; bus1.D_SIZE = s_t[i];
      bus1.D_ADDR = a_t[i]; bus1.D_WDATA = w_t[i];
      #1;
      total++;
      if ({bus1.D_GNT, bus1.I_GNT} !== 2'b10) begin
        bad++; $display("FAIL store_gnt[%0d]: d/i gnt=%b required 10", i, {bus1.D_GNT, bus1.I_GNT});
      end
      sb1.push_back('{1'b1, 32'h0, 1'b0});
      @(negedge CLK);
      bus1.D_REQ = 1'b0;
      #1;
      aw = {a_t[i][31:2], 2'b00};
      total++;
      if (bus1.MEM_ADDR !== aw || bus1.MEM_WE !== 1'b1) begin
        bad++; $display("FAIL store_addr[%0d]: addr=%h we=%b required %h 1",
                        i, bus1.MEM_ADDR, bus1.MEM_WE, aw);
      end
      total++;
      if (bus1.MEM_BE !== b_t[i] || bus1.MEM_IN !== i_t[i]) begin
        bad++; $display("FAIL store_lane[%0d]: be=%b in=%h required %b %h",
                        i, bus1.MEM_BE, bus1.MEM_IN, b_t[i], i_t[i]);
      end
      wait_rv(1'b0, n, is_d, data, mis);
      total++;
      if (n != 1 || bus1.MEM_WE !== 1'b0 || bus1.MEM_BE !== 4'b0000) begin
        bad++; $display("FAIL store_done[%0d]: rvalid cycle=%0d we=%b be=%b required 2 0 0000",
                        i, n + 1, bus1.MEM_WE, bus1.MEM_BE);
      end
      if (n >= 0) begin
        total++;
        if (sb1.size() == 0) begin
          bad++; $display("FAIL store_unexpected[%0d]: response with empty scoreboard", i);
        end else begin
          e = sb1.pop_front();
          if (is_d !== e.is_d || data !== e.data || mis !== e.mis) begin
            bad++; $display("FAIL store_resp[%0d]: d=%b data=%h mis=%b required d=%b data=%h mis=%b",
                            i, is_d, data, mis, e.is_d, e.data, e.mis);
          end
        end
      end
      $display("store addr=%h wdata=%h be=%b", a_t[i], w_t[i], b_t[i]);
    end
  endtask

  task automatic test_misalign();
    int n; bit is_d; logic [31:0] data; bit mis; exp_t e;
    @(negedge CLK);
    bus1.D_REQ = 1'b1; bus1.D_WE = 1'b0; bus1.D_SIZE = 2'b10; bus1.D_ADDR = 32'h0000_0102;
    #1;
    total++;
    if (bus1.D_GNT !== 1'b1) begin
      bad++; $display("FAIL mis_gnt: D_GNT=%b required 1", bus1.D_GNT);
    end
    sb1.push_back('{1'b1, 32'h0, 1'b1});
    @(negedge CLK);
    bus1.D_REQ = 1'b0;
    bus1.I_REQ = 1'b1; bus1.I_ADDR = 32'h0000_0300; bus1.MEM_OUT = 32'h0000_0055;
    #1;
    total++;
    if (bus1.D_RVALID !== 1'b1) begin
      bad++; $display("FAIL mis_rvalid: D_RVALID=%b required 1", bus1.D_RVALID);
    end else begin
      total++;
      if (sb1.size() == 0) begin
        bad++; $display("FAIL mis_unexpected: response with empty scoreboard");
      end else begin
        e = sb1.pop_front();
        if (bus1.D_RDATA !== e.data || bus1.D_MISALIGN !== e.mis) begin
          bad++; $display("FAIL mis_resp: data=%h mis=%b required %h %b",
                          bus1.D_RDATA, bus1.D_MISALIGN, e.data, e.mis);
        end
      end
    end
    total++;
    if (bus1.MEM_WE !== 1'b0 || bus1.MEM_ADDR !== 32'h0000_0040) begin
      bad++; $display("FAIL mis_nomem: we=%b addr=%h required 0 00000040", bus1.MEM_WE, bus1.MEM_ADDR);
    end
    total++;
    if (bus1.I_GNT !== 1'b1) begin
      bad++; $display("FAIL mis_next_gnt: I_GNT=%b required 1", bus1.I_GNT);
    end
    sb1.push_back('{1'b0, 32'h0000_0055, 1'b0});
    @(negedge CLK);
    bus1.I_REQ = 1'b0;
    #1;
    total++;
    if (bus1.MEM_ADDR !== 32'h0000_0300 || bus1.D_MISALIGN !== 1'b0) begin
      bad++; $display("FAIL mis_follow: addr=%h mis=%b required 00000300 0", bus1.MEM_ADDR, bus1.D_MISALIGN);
    end
    wait_rv(1'b0, n, is_d, data, mis);
    total++;
    if (n != 1) begin
      bad++; $display("FAIL mis_fetch_lat: rvalid after %0d cycles required 1", n);
    end
    if (n >= 0) begin
      total++;
      if (sb1.size() == 0) begin
        bad++; $display("FAIL mis_fetch_unexpected: response with empty scoreboard");
      end else begin
        e = sb1.pop_front();
        if (is_d !== e.is_d || data !== e.data) begin
          bad++; $display("FAIL mis_fetch_data: d=%b data=%h required d=%b data=%h",
                          is_d, data, e.is_d, e.data);
        end
      end
    end
    $display("misaligned lw addr=00000102 then fetch addr=00000300 rdata=%h", data);
  endtask

  task automatic test_back_to_back();
    bit exp_d; bit exp_i; exp_t e;
    @(negedge CLK);
    bus1.I_REQ = 1'b1; bus1.I_ADDR = 32'h0000_0500;
    bus1.D_REQ = 1'b1; bus1.D_WE = 1'b0; bus1.D_SIZE = 2'b10; bus1.D_ADDR = 32'h0000_0400;
    bus1.MEM_OUT = 32'h1122_3344;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) @(negedge CLK);
      if (k == 8) begin
        bus1.I_REQ = 1'b0; bus1.D_REQ = 1'b0;
      end
      #1;
      exp_d = 1'b0; exp_i = 1'b0;
      if ((k % 2) == 0 && k < 8) begin
`ifdef CORE_MEM_ARB_RR_EN
        if ((k % 4) == 0) exp_d = 1'b1; else exp_i = 1'b1;
`else
        exp_d = 1'b1;
`endif
      end
      total++;
      if ({bus1.D_GNT, bus1.I_GNT} !== {exp_d, exp_i}) begin
        bad++; $display("FAIL b2b_gnt[%0d]: d/i gnt=%b required %b",
                        k, {bus1.D_GNT, bus1.I_GNT}, {exp_d, exp_i});
      end
      if (bus1.I_RVALID || bus1.D_RVALID) begin
        total++;
        if (sb1.size() == 0) begin
          bad++; $display("FAIL b2b_unexpected[%0d]: response with empty scoreboard", k);
        end else begin
          e = sb1.pop_front();
          if (bus1.D_RVALID !== e.is_d ||
              (e.is_d ? bus1.D_RDATA : bus1.I_RDATA) !== e.data) begin
            bad++; $display("FAIL b2b_resp[%0d]: d_rvalid=%b data=%h required d=%b data=%h",
                            k, bus1.D_RVALID, e.is_d ? bus1.D_RDATA : bus1.I_RDATA,
                            e.is_d, e.data);
          end
        end
      end
      if (bus1.D_GNT) sb1.push_back('{1'b1, 32'h1122_3344, 1'b0});
      if (bus1.I_GNT) sb1.push_back('{1'b0, 32'h1122_3344, 1'b0});
      if (bus1.D_GNT || bus1.I_GNT)
        $display("b2b cycle=%0d grant=%s", k, bus1.D_GNT ? "D" : "I");
    end
    total++;
    if (sb1.size() != 0) begin
      bad++; $display("FAIL b2b_drain: %0d responses outstanding required 0", sb1.size());
      sb1.delete();
    end
  endtask

  task automatic test_load();
    logic [31:0] a_t [5] = '{32'h0000_0201, 32'h0000_0201, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004};
    logic [1:0]  s_t [5] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10};
    bit          u_t [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] m_t [5] = '{32'h0000_8000, 32'h0000_8000, 32'hF00D_1234, 32'hF00D_1234, 32'h89AB_CDEF};
    logic [31:0] r_t [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_F00D, 32'h0000_00F0, 32'h89AB_CDEF};
    int n; bit is_d; logic [31:0] data; bit mis; exp_t e;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      bus3.D_REQ = 1'b1; bus3.D_WE = 1'b0; bus3.D_SIZE = s_t[i];
      bus3.D_UNSIGNED = u_t[i]; bus3.D_ADDR = a_t[i]; bus3.MEM_OUT = m_t[i];
      #1;
      total++;
      if (bus3.D_GNT !== 1'b1) begin
        bad++; $display("FAIL load_gnt[%0d]: D_GNT=%b required 1", i, bus3.D_GNT);
      end
      sb3.push_back('{1'b1, r_t[i], 1'b0});
      @(negedge CLK);
      bus3.D_REQ = 1'b0;
      #1;
      total++;
      if (bus3.MEM_ADDR !== {a_t[i][31:2], 2'b00} || bus3.MEM_WE !== 1'b0) begin
        bad++; $display("FAIL load_addr[%0d]: addr=%h we=%b required %h 0",
                        i, bus3.MEM_ADDR, bus3.MEM_WE, {a_t[i][31:2], 2'b00});
      end
      wait_rv(1'b1, n, is_d, data, mis);
      total++;
      if (n != 3) begin
        bad++; $display("FAIL load_lat[%0d]: rvalid cycle=%0d required 4", i, n + 1);
      end
      if (n >= 0) begin
        total++;
        if (sb3.size() == 0) begin
          bad++; $display("FAIL load_unexpected[%0d]: response with empty scoreboard", i);
        end else begin
          e = sb3.pop_front();
          if (is_d !== e.is_d || data !== e.data || mis !== e.mis) begin
            bad++; $display("FAIL load_data[%0d]: d=%b data=%h mis=%b required d=%b data=%h mis=%b",
                            i, is_d, data, mis, e.is_d, e.data, e.mis);
          end
        end
      end
      $display("load addr=%h size=%b uns=%b rdata=%h", a_t[i], s_t[i], u_t[i], data);
    end
  endtask

  task automatic test_reset_mid();
    int n; bit is_d; logic [31:0] data; bit mis; exp_t e;
    @(negedge CLK);
    bus3.I_REQ = 1'b1; bus3.I_ADDR = 32'h0000_0600; bus3.MEM_OUT = 32'h0000_DEAD;
    #1;
    total++;
    if (bus3.I_GNT !== 1'b1) begin
      bad++; $display("FAIL rstmid_gnt: I_GNT=%b required 1", bus3.I_GNT);
    end
    @(negedge CLK);
    bus3.I_REQ = 1'b0;
    #1;
    total++;
    if (bus3.MEM_ADDR !== 32'h0000_0600) begin
      bad++; $display("FAIL rstmid_addr: MEM_ADDR=%h required 00000600", bus3.MEM_ADDR);
    end
    @(negedge CLK);
    rst3 = 1'b1;
    @(negedge CLK);
    rst3 = 1'b0;
    #1;
    total++;
    if ({bus3.MEM_ADDR, bus3.MEM_IN, bus3.MEM_BE, bus3.MEM_WE, bus3.I_RVALID,
         bus3.I_RDATA, bus3.D_RVALID, bus3.D_RDATA, bus3.D_MISALIGN,
         bus3.I_GNT, bus3.D_GNT} !== '0) begin
      bad++; $display("FAIL rstmid_zero: addr=%h drdata=%h ivld=%b required all 0",
                      bus3.MEM_ADDR, bus3.D_RDATA, bus3.I_RVALID);
    end
    @(negedge CLK);
    bus3.I_REQ = 1'b1; bus3.I_ADDR = 32'h0000_0700; bus3.MEM_OUT = 32'h0000_BEEF;
    #1;
    total++;
    if (bus3.I_GNT !== 1'b1 || bus3.I_RVALID !== 1'b0) begin
      bad++; $display("FAIL rstmid_regnt: gnt=%b rvalid=%b required 1 0", bus3.I_GNT, bus3.I_RVALID);
    end
    sb3.push_back('{1'b0, 32'h0000_BEEF, 1'b0});
    @(negedge CLK);
    bus3.I_REQ = 1'b0;
    #1;
    wait_rv(1'b1, n, is_d, data, mis);
    total++;
    if (n != 3) begin
      bad++; $display("FAIL rstmid_lat: rvalid after %0d cycles required 3", n);
    end
    if (n >= 0) begin
      total++;
      if (sb3.size() == 0) begin
        bad++; $display("FAIL rstmid_unexpected: response with empty scoreboard");
      end else begin
        e = sb3.pop_front();
        if (is_d !== e.is_d || data !== e.data) begin
          bad++; $display("FAIL rstmid_data: d=%b data=%h required d=%b data=%h",
                          is_d, data, e.is_d, e.data);
        end
      end
    end
    $display("reset mid-fetch, refetch addr=00000700 rdata=%h", data);
  endtask

  initial begin
    clear_inputs();
    rst1 = 1'b1;
    rst3 = 1'b1;
    test_reset();
    test_fetch();
    test_store();
    test_misalign();
    test_back_to_back();
    test_load();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
